// File: rtl/mips_pkg.sv
// Shared register-file writeback definitions for the MIPS core.
// Holds default widths, the zero-register index, the writeback request record and the arbiter state encoding.
package mips_pkg;

    localparam int DATA_W_DFLT = 32;
    localparam int ADDR_W_DFLT = 5;

    localparam logic [ADDR_W_DFLT-1:0] REG_ZERO = '0;

    // One writeback request; used for both the pipeline and mul/div requesters.
    typedef struct packed {
        logic                   valid;
        logic [ADDR_W_DFLT-1:0] dest;
        logic [DATA_W_DFLT-1:0] data;
    } wb_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for outstanding mul/div results.
// Sets a bit on issue, clears it on commit, and answers the hazard-unit queries from registered state.
module wb_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              iss_ready,
    input  logic              cmt_valid,
    input  logic [ADDR_W-1:0] cmt_dest,
    input  logic [ADDR_W-1:0] q_src1,
    input  logic [ADDR_W-1:0] q_src2,
    output logic              q_busy1,
    output logic              q_busy2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            iss_fire;

    always_comb begin
        iss_ready = ~pending_q[iss_dest];
        iss_fire  = iss_valid & iss_ready;
        q_busy1   = pending_q[q_src1];
        q_busy2   = pending_q[q_src2];
    end

    // Issue and commit never target the same register in one cycle, so their order here is irrelevant.
    always_comb begin
        pending_d = pending_q;
        if (cmt_valid) begin
            pending_d[cmt_dest] = 1'b0;
        end
        if (iss_fire) begin
            pending_d[iss_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (fixed priority) versus the mul/div unit,
// with a starvation counter that asks the pipeline to bubble WB when mul/div waits too long.
module wb_port_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DFLT,
    parameter int ADDR_W       = ADDR_W_DFLT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_dest,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] q_src1,
    input  logic [ADDR_W-1:0] q_src2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic              stall_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_req_t    a_req;
    wb_req_t    b_req;
    wb_req_t    win;
    logic       b_fire;
    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;
    arb_state_t state_q;
    arb_state_t state_d;

    // Combinational grant: the pipeline can never be back-pressured, so it always wins.
    always_comb begin
        a_req   = '{valid: a_valid, dest: a_dest, data: a_data};
        b_req   = '{valid: b_valid, dest: b_dest, data: b_data};
        b_ready = b_valid & ~a_valid;
        b_fire  = b_valid & b_ready;
        win     = '0;
        if (a_valid) begin
            win = a_req;
        end else if (b_valid) begin
            win = b_req;
        end
        rf_we   = win.valid && (win.dest != REG_ZERO);
        rf_dest = win.dest;
        rf_data = win.data;
    end

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_dest  (iss_dest),
        .iss_ready (iss_ready),
        .cmt_valid (b_fire),
        .cmt_dest  (b_dest),
        .q_src1    (q_src1),
        .q_src2    (q_src2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2)
    );

    // The FSM looks at the next count so stall_req rises on the same edge the count hits the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_valid || b_fire) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wait_cnt_d == LIMIT) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (b_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        stall_req = (state_q == ST_STALL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            state_q    <= ST_IDLE;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: grant mux, scoreboard, starvation stall and async reset.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_dest;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_dest;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_dest;
    logic        iss_ready;
    logic [4:0]  q_src1;
    logic [4:0]  q_src2;
    logic        q_busy1;
    logic        q_busy2;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_dest    (a_dest),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_dest    (b_dest),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_dest  (iss_dest),
        .iss_ready (iss_ready),
        .q_src1    (q_src1),
        .q_src2    (q_src2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_dest   (rf_dest),
        .rf_data   (rf_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven and outputs sampled from here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_dest    = 5'd0;
        a_data    = 32'h0;
        b_valid   = 1'b0;
        b_dest    = 5'd0;
        b_data    = 32'h0;
        iss_valid = 1'b0;
        iss_dest  = 5'd0;
        q_src1    = 5'd5;
        q_src2    = 5'd0;

        tick();
        settle();
        chk("rst_stall", stall_req, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_bready", b_ready, 0);
        chk("rst_busy1", q_busy1, 0);
        chk("idle_dest", rf_dest, 0);
        chk("idle_data", rf_data, 0);
        tick();
        rst = 1'b0;

        // A writes r5 while B is also valid: A wins in the same cycle.
        a_valid = 1'b1; a_dest = 5'd5; a_data = 32'h1234;
        b_valid = 1'b1; b_dest = 5'd1; b_data = 32'hBBBB;
        settle();
        chk("a_we", rf_we, 1);
        chk("a_dest", rf_dest, 5);
        chk("a_data", rf_data, 32'h0000_1234);
        chk("a_bready", b_ready, 0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;

        // Issue r7: no same-cycle bypass, then pending next cycle.
        iss_valid = 1'b1; iss_dest = 5'd7; q_src1 = 5'd7;
        settle();
        chk("iss7_ready", iss_ready, 1);
        chk("iss7_nobypass", q_busy1, 0);
        tick();
        iss_valid = 1'b0;
        settle();
        chk("r7_busy", q_busy1, 1);
        chk("r7_issready", iss_ready, 0);

        // B commits r7 with A idle.
        b_valid = 1'b1; b_dest = 5'd7; b_data = 32'hDEAD;
        settle();
        chk("b7_ready", b_ready, 1);
        chk("b7_we", rf_we, 1);
        chk("b7_dest", rf_dest, 7);
        chk("b7_data", rf_data, 32'h0000_DEAD);
        chk("b7_busy_pre", q_busy1, 1);
        tick();
        b_valid = 1'b0;
        settle();
        chk("b7_busy_post", q_busy1, 0);
        chk("b7_issready", iss_ready, 1);

        // Starvation: issue r9, then A valid every cycle while B holds r9.
        iss_valid = 1'b1; iss_dest = 5'd9; q_src1 = 5'd9;
        tick();
        iss_valid = 1'b0;
        a_valid = 1'b1; a_dest = 5'd2; a_data = 32'h2222;
        b_valid = 1'b1; b_dest = 5'd9; b_data = 32'h9999;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("starve_nostall%0d", i), stall_req, 0);
            chk($sformatf("starve_bready%0d", i), b_ready, 0);
            tick();
        end
        settle();
        chk("starve_stall", stall_req, 1);
        chk("starve_busy9", q_busy1, 1);
        a_valid = 1'b0;
        settle();
        chk("starve_bcommit", b_ready, 1);
        chk("starve_we", rf_we, 1);
        chk("starve_dest", rf_dest, 9);
        tick();
        b_valid = 1'b0;
        settle();
        chk("starve_release", stall_req, 0);
        chk("starve_busy9_clr", q_busy1, 0);

        // Writes to r0 never assert rf_we; B handshake still completes.
        a_valid = 1'b1; a_dest = 5'd0; a_data = 32'h5555;
        settle();
        chk("a_r0_we", rf_we, 0);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_dest = 5'd0; b_data = 32'h6666;
        settle();
        chk("b_r0_ready", b_ready, 1);
        chk("b_r0_we", rf_we, 0);
        tick();
        b_valid = 1'b0;

        // Same-cycle issue r3 and commit r4.
        iss_valid = 1'b1; iss_dest = 5'd4;
        tick();
        iss_dest = 5'd3;
        b_valid = 1'b1; b_dest = 5'd4; b_data = 32'h4444;
        q_src1 = 5'd3; q_src2 = 5'd4;
        settle();
        chk("dual_issready", iss_ready, 1);
        chk("dual_bready", b_ready, 1);
        chk("dual_pre4", q_busy2, 1);
        tick();
        iss_valid = 1'b0; b_valid = 1'b0;
        settle();
        chk("dual_pend3", q_busy1, 1);
        chk("dual_pend4", q_busy2, 0);

        // Async reset mid-wait with r10 pending and stall_req high.
        iss_valid = 1'b1; iss_dest = 5'd10;
        tick();
        iss_valid = 1'b0;
        a_valid = 1'b1; a_dest = 5'd2; a_data = 32'h7777;
        b_valid = 1'b1; b_dest = 5'd10; b_data = 32'hAAAA;
        q_src1 = 5'd10; q_src2 = 5'd3;
        for (int i = 0; i < 4; i++) tick();
        settle();
        chk("pre_rst_stall", stall_req, 1);
        chk("pre_rst_busy10", q_busy1, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_stall", stall_req, 0);
        chk("arst_busy10", q_busy1, 0);
        chk("arst_busy3", q_busy2, 0);
        chk("arst_comb_we", rf_we, 1);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
